// File: rtl/simple_isa_pkg.sv
// Shared ISA constants for the issue stage: instruction width, bubble encoding, field ranges.
package simple_isa_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned CLASS_HI = 15;
   localparam int unsigned CLASS_LO = 14;
   localparam int unsigned RA_HI    = 13;
   localparam int unsigned RA_LO    = 11;
   localparam int unsigned RB_HI    = 10;
   localparam int unsigned RB_LO    = 8;
   localparam int unsigned FUNC_HI  = 7;
   localparam int unsigned FUNC_LO  = 4;

   localparam logic [1:0]         CLASS_ARITH = 2'b11;
   localparam logic [3:0]         FUNC_HLT    = 4'b1111;
   // Arith class with func 4'b1110: no write, no output, never matches a forwarding compare
   localparam logic [INSTR_W-1:0] BUBBLE      = 16'hC0E0;

   function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
      return (instr[CLASS_HI:CLASS_LO] == CLASS_ARITH) && (instr[FUNC_HI:FUNC_LO] == FUNC_HLT);
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// Small power-of-two FIFO with clear; head is visible on rdata_o whenever not empty.
module issue_fifo #(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned LVL_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LVL_W-1:0]  level_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Clear wins; a full FIFO never overwrites, an empty one never underflows
   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
         rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
         level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/instruction_issue_unit.sv
// Issue stage: buffers fetched instructions and presents a three-slot issue window to decode.
// Optional build macro HALT_DETECT_EN enables sticky halt on an issued HLT.
module instruction_issue_unit
   import simple_isa_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned PC_W  = 16,
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               in_ready,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic [INSTR_W-1:0] command,
   output logic [INSTR_W-1:0] before_command,
   output logic [INSTR_W-1:0] two_before_command,
   output logic [PC_W-1:0]    out_pc,
   output logic [LVL_W-1:0]   fifo_level,
   output logic               halted
);

   localparam int unsigned DATA_W = PC_W + INSTR_W;

   logic [DATA_W-1:0]  head;
   logic [INSTR_W-1:0] head_instr;
   logic [PC_W-1:0]    head_pc;
   logic               fifo_full, fifo_empty;
   logic               push, pop;

   logic [INSTR_W-1:0] cmd_q, cmd_d;
   logic [INSTR_W-1:0] bef_q, bef_d;
   logic [INSTR_W-1:0] two_q, two_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;
   logic               halted_q, halted_d;

   assign head_instr = head[INSTR_W-1:0];
   assign head_pc    = head[DATA_W-1:INSTR_W];

   // Ready depends only on registered state and the flush input, never on this cycle's pop
   assign in_ready = !fifo_full && !flush && !halted_q;
   assign push     = in_valid && in_ready;
   assign pop      = !flush && !stall && !fifo_empty && !halted_q;

   issue_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (flush),
      .wdata_i ({in_pc, in_instr}),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Window priority: flush > stall > advance; bubbles shift through history like instructions
   always_comb begin
      cmd_d    = cmd_q;
      bef_d    = bef_q;
      two_d    = two_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      if (flush || !stall) begin
         two_d   = bef_q;
         bef_d   = cmd_q;
         cmd_d   = BUBBLE;
         pc_d    = '0;
         valid_d = 1'b0;
         if (pop) begin
            cmd_d   = head_instr;
            pc_d    = head_pc;
            valid_d = 1'b1;
`ifdef HALT_DETECT_EN
            if (is_hlt(head_instr)) halted_d = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q    <= BUBBLE;
         bef_q    <= BUBBLE;
         two_q    <= BUBBLE;
         pc_q     <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         cmd_q    <= cmd_d;
         bef_q    <= bef_d;
         two_q    <= two_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   assign command            = cmd_q;
   assign before_command     = bef_q;
   assign two_before_command = two_q;
   assign out_pc             = pc_q;
   assign out_valid          = valid_q;
   assign halted             = halted_q;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Scoreboard bench for instruction_issue_unit: queue-based reference model, per-edge monitor.
module tb_instruction_issue_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PC_W  = 16;
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam logic [15:0] BUB   = 16'hC0E0;

   typedef struct packed {
      logic [15:0]      cmd;
      logic [15:0]      bef;
      logic [15:0]      two;
      logic             ov;
      logic [PC_W-1:0]  pc;
      logic [LVL_W-1:0] lvl;
      logic             hlt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [15:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              in_ready;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic [15:0]       command;
   logic [15:0]       before_command;
   logic [15:0]       two_before_command;
   logic [PC_W-1:0]   out_pc;
   logic [LVL_W-1:0]  fifo_level;
   logic              halted;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   // Reference model state
   logic [31:0]     mq[$];
   logic [15:0]     w_cmd, w_bef, w_two;
   logic            m_ov, m_halt;
   logic [PC_W-1:0] m_pc;

   instruction_issue_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_valid           (in_valid),
      .in_instr           (in_instr),
      .in_pc              (in_pc),
      .in_ready           (in_ready),
      .stall              (stall),
      .flush              (flush),
      .out_valid          (out_valid),
      .command            (command),
      .before_command     (before_command),
      .two_before_command (two_before_command),
      .out_pc             (out_pc),
      .fifo_level         (fifo_level),
      .halted             (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      w_cmd = BUB; w_bef = BUB; w_two = BUB;
      m_ov = 1'b0; m_pc = '0; m_halt = 1'b0;
   endtask

   // One cycle: drive at negedge, check ready, advance model, queue expected post-edge state
   task automatic step(input logic v, input logic [15:0] ins, input logic [PC_W-1:0] pc,
                       input logic st, input logic fl);
      logic        ready;
      logic [31:0] e;
      exp_t        x;
      @(negedge clk);
      in_valid = v; in_instr = ins; in_pc = pc; stall = st; flush = fl;
      #1;
      ready = (mq.size() < DEPTH) && !fl && !m_halt;
      chk("in_ready", 32'(in_ready), 32'(ready));
      if (fl) begin
         mq.delete();
         w_two = w_bef; w_bef = w_cmd; w_cmd = BUB; m_ov = 1'b0; m_pc = '0;
      end else if (!st) begin
         w_two = w_bef; w_bef = w_cmd;
         if (!m_halt && mq.size() > 0) begin
            e = mq.pop_front();
            w_cmd = e[15:0]; m_pc = e[31:16]; m_ov = 1'b1;
`ifdef HALT_DETECT_EN
            if (e[15:14] == 2'b11 && e[7:4] == 4'hF) m_halt = 1'b1;
`endif
         end else begin
            w_cmd = BUB; m_pc = '0; m_ov = 1'b0;
         end
      end
      if (v && ready) mq.push_back({pc, ins});
      x.cmd = w_cmd; x.bef = w_bef; x.two = w_two; x.ov = m_ov; x.pc = m_pc;
      x.lvl = LVL_W'(mq.size()); x.hlt = m_halt;
      exp_q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare every post-edge DUT state against the queued expectation
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("command",    32'(command),            32'(x.cmd));
            chk("before",     32'(before_command),     32'(x.bef));
            chk("two_before", 32'(two_before_command), 32'(x.two));
            chk("out_valid",  32'(out_valid),          32'(x.ov));
            chk("out_pc",     32'(out_pc),             32'(x.pc));
            chk("fifo_level", 32'(fifo_level),         32'(x.lvl));
            chk("halted",     32'(halted),             32'(x.hlt));
         end
      end
   end

   initial begin
      logic [15:0] r;
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; stall = 1'b0; flush = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-stream with three entries buffered
      for (int i = 0; i < 3; i++) step(1'b1, 16'h2000 + 16'(i), PC_W'(16'h100 + i), 1'b1, 1'b0);
      chk("pre_reset_level", 32'(fifo_level), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_command",   32'(command),            32'(BUB));
      chk("rst_before",    32'(before_command),     32'(BUB));
      chk("rst_two",       32'(two_before_command), 32'(BUB));
      chk("rst_out_valid", 32'(out_valid),          32'd0);
      chk("rst_level",     32'(fifo_level),         32'd0);
      chk("rst_out_pc",    32'(out_pc),             32'd0);
      chk("rst_halted",    32'(halted),             32'd0);
      model_reset();
      in_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Three-word stream, then two empty edges
      step(1'b1, 16'h4A08, PC_W'(16'h0010), 1'b0, 1'b0);
      step(1'b1, 16'hC850, PC_W'(16'h0012), 1'b0, 1'b0);
      step(1'b1, 16'h8105, PC_W'(16'h0014), 1'b0, 1'b0);
      step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
      chk("stream_two",    32'(two_before_command), 32'h4A08);
      chk("stream_before", 32'(before_command),     32'hC850);
      chk("stream_cmd",    32'(command),            32'h8105);
      step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
      chk("empty_cmd",   32'(command),        32'(BUB));
      chk("empty_bef",   32'(before_command), 32'(BUB));
      chk("empty_valid", 32'(out_valid),      32'd0);

      // Fill under stall; fifth word refused; then drain in order
      for (int i = 0; i < 5; i++) step(1'b1, 16'h1001 + 16'(i), PC_W'(16'h200 + i), 1'b1, 1'b0);
      chk("full_level", 32'(fifo_level), 32'd4);
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, '0, 1'b0, 1'b0);

      // Flush at level 3 with a word offered, flush and stall together
      for (int i = 0; i < 3; i++) step(1'b1, 16'h3300 + 16'(i), PC_W'(16'h300 + i), 1'b1, 1'b0);
      step(1'b1, 16'h7777, PC_W'(16'h0777), 1'b1, 1'b1);
      chk("flush_level", 32'(fifo_level), 32'd0);
      chk("flush_cmd",   32'(command),    32'(BUB));
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, '0, 1'b0, 1'b0);

      // Randomised traffic; HLT encodings avoided so halt behaviour is exercised deliberately below
      for (int i = 0; i < 600; i++) begin
         r = 16'($urandom);
         if (r[15:14] == 2'b11 && r[7:4] == 4'hF) r[7] = 1'b0;
         step($urandom_range(0, 9) < 7, r, PC_W'($urandom),
              $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, '0, 1'b0, 1'b0);

      // HLT issue followed by more traffic
      step(1'b1, 16'hC0F0, PC_W'(16'h0400), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h5500 + 16'(i), PC_W'(16'h402 + i), 1'b0, 1'b0);
      step(1'b1, 16'h6600, PC_W'(16'h0500), 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h6601 + 16'(i), PC_W'(16'h502 + i), 1'b0, 1'b0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
